dmem_port_arbiter: RTL and testbench

Sequences the two issue lanes' data-memory accesses (lane A = older, lane B = younger instruction of a dual-issued pair) onto one single-ported data memory with a valid/ready request channel and a separate read-response channel. It sits between the execute stage's ALU results and the memory stage. It stalls the pipeline while an access pair is outstanding. It returns both lanes' load data together on a single completion cycle.

---
 rtl/dmem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Serialises the data-memory accesses of a dual-issued instruction pair onto a
// single-ported memory. Lane A (older instruction) is always serviced before
// lane B, so a B load that aliases an A store sees the stored value. The
// pipeline is stalled while the pair is in flight, and both lanes' load data
// are presented together on a one-cycle done pulse.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   reqA/reqB           lane wants a memory access (held while stall=1)
//   weA/weB             1 = store, 0 = load
//   addrA/addrB         byte address from the ALU
//   wdataA/wdataB       store data
//   stall               freezes fetch/decode/execute (combinational)
//   done                one-cycle completion pulse
//   rdataA/rdataB       load results, valid when done=1
//   mem_req/mem_we      request valid / request is a write
//   mem_addr/mem_wdata  request address / write data
//   mem_ready           memory accepts the request this cycle
//   mem_rvalid          read data valid (once per accepted read)
//   mem_rdata           read data
module dmem_port_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqA,
  input  logic                  reqB,
  input  logic                  weA,
  input  logic                  weB,
  input  logic [DATA_WIDTH-1:0] addrA,
  input  logic [DATA_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0] wdataA,
  input  logic [DATA_WIDTH-1:0] wdataB,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdataA,
  output logic [DATA_WIDTH-1:0] rdataB,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_A = 3'd1,
    WAIT_A  = 3'd2,
    ISSUE_B = 3'd3,
    WAIT_B  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state;
  state_t state_n;

  logic b_pend;
  logic wea_q;
  logic web_q;
  logic we_a_n;
  logic we_b_n;

  // Next-state selection. The lane's store/load kind and the B-pending flag
  // are taken from copies captured while idle, so the sequence does not
  // depend on the inputs once the pair has started.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (reqA) begin
          state_n = ISSUE_A;
        end else if (reqB) begin
          state_n = ISSUE_B;
        end
      end
      ISSUE_A: begin
        if (mem_ready) begin
          if (wea_q) begin
            state_n = b_pend ? ISSUE_B : DONE;
          end else begin
            state_n = WAIT_A;
          end
        end
      end
      WAIT_A: begin
        if (mem_rvalid) begin
          state_n = b_pend ? ISSUE_B : DONE;
        end
      end
      ISSUE_B: begin
        if (mem_ready) begin
          state_n = web_q ? DONE : WAIT_B;
        end
      end
      WAIT_B: begin
        if (mem_rvalid) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // When leaving IDLE the latched copies are not yet valid, so the write
  // strobe for the first issue cycle comes straight from the lane input.
  always_comb begin
    we_a_n = (state == IDLE) ? weA : wea_q;
    we_b_n = (state == IDLE) ? weB : web_q;
  end

  // State register plus registered request/done strobes. mem_req and mem_we
  // are produced from the next state so they are flops and carry no
  // combinational path from mem_ready. Read data is only captured in the
  // matching WAIT state, which also discards stray or post-reset responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      b_pend  <= 1'b0;
      wea_q   <= 1'b0;
      web_q   <= 1'b0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      done    <= 1'b0;
      rdataA  <= '0;
      rdataB  <= '0;
    end else begin
      state   <= state_n;
      mem_req <= (state_n == ISSUE_A) || (state_n == ISSUE_B);
      mem_we  <= ((state_n == ISSUE_A) && we_a_n) ||
                 ((state_n == ISSUE_B) && we_b_n);
      done    <= (state_n == DONE);
      if (state == IDLE) begin
        b_pend <= reqB;
        wea_q  <= weA;
        web_q  <= weB;
      end
      if ((state == WAIT_A) && mem_rvalid) begin
        rdataA <= mem_rdata;
      end
      if ((state == WAIT_B) && mem_rvalid) begin
        rdataB <= mem_rdata;
      end
    end
  end

  // Lane operands are held stable by the pipeline while stalled, so the
  // request address/data can be steered from the lane inputs directly.
  assign mem_addr  = (state == ISSUE_B) ? addrB  : addrA;
  assign mem_wdata = (state == ISSUE_B) ? wdataB : wdataA;

  assign stall = ((state == IDLE) && (reqA || reqB)) ||
                 (state == ISSUE_A) || (state == WAIT_A) ||
                 (state == ISSUE_B) || (state == WAIT_B);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } memreq_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } result_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          reqA = 1'b0;
  logic          reqB = 1'b0;
  logic          weA = 1'b0;
  logic          weB = 1'b0;
  logic [DW-1:0] addrA = '0;
  logic [DW-1:0] addrB = '0;
  logic [DW-1:0] wdataA = '0;
  logic [DW-1:0] wdataB = '0;
  logic          stall;
  logic          done;
  logic [DW-1:0] rdataA;
  logic [DW-1:0] rdataB;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  memreq_t expReqQ[$];
  result_t expResQ[$];
  logic [DW-1:0] refMem[logic [DW-1:0]];
  logic [DW-1:0] physMem[logic [DW-1:0]];

  int checks = 0;
  int failures = 0;
  int doneCount = 0;
  int acceptCount = 0;

  int readyPct = 100;
  int rdDelayMin = 1;
  int rdDelayMax = 1;
  int readyHold = 0;
  bit spuriousEn = 1'b0;

  bit            rdPending = 1'b0;
  int            rdCount = 0;
  logic [DW-1:0] rdData = '0;
  bit            prevReq = 1'b0;
  bit            prevAcc = 1'b0;
  memreq_t       prevSnap = '0;

  logic [DW-1:0] lastA = '0;
  logic [DW-1:0] lastB = '0;

  dmem_port_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .reqA       (reqA),
    .reqB       (reqB),
    .weA        (weA),
    .weB        (weB),
    .addrA      (addrA),
    .addrB      (addrB),
    .wdataA     (wdataA),
    .wdataB     (wdataB),
    .stall      (stall),
    .done       (done),
    .rdataA     (rdataA),
    .rdataB     (rdataB),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // Contents of a never-written word, shared by the reference view of memory
  // and by the memory responder so both start from the same image.
  function automatic logic [DW-1:0] initVal(input logic [DW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] refRead(input logic [DW-1:0] a);
    return refMem.exists(a) ? refMem[a] : initVal(a);
  endfunction

  function automatic logic [DW-1:0] physRead(input logic [DW-1:0] a);
    return physMem.exists(a) ? physMem[a] : initVal(a);
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  task automatic preload(input logic [DW-1:0] a, input logic [DW-1:0] v);
    refMem[a] = v;
    physMem[a] = v;
  endtask

  // Memory responder. Every falling edge it decides mem_ready and mem_rvalid
  // for the coming rising edge. An accepted request is checked against the
  // expected-request queue (program order A then B), a write updates the
  // memory image at once, and a read returns the current word after a random
  // delay of at least one cycle. Stray rvalid pulses are only generated when
  // no read is outstanding. A request held without acceptance must not move.
  always @(negedge clk) begin
    memreq_t e;
    mem_rvalid = 1'b0;
    if (rdPending) begin
      rdCount--;
      if (rdCount <= 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdData;
        rdPending  = 1'b0;
      end
    end else if (spuriousEn && ($urandom_range(0, 3) == 0)) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
    end
    if (mem_req && (readyHold > 0)) begin
      mem_ready = 1'b0;
      readyHold--;
    end else begin
      mem_ready = ($urandom_range(1, 100) <= readyPct);
    end
    if (rst && mem_req && prevReq && !prevAcc) begin
      checkOutput("held_mem_we", 32'(mem_we), 32'(prevSnap.we));
      checkOutput("held_mem_addr", mem_addr, prevSnap.addr);
      checkOutput("held_mem_wdata", mem_wdata, prevSnap.wdata);
    end
    prevReq  = rst && mem_req;
    prevAcc  = mem_req && mem_ready;
    prevSnap = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
    if (rst && mem_req && mem_ready) begin
      acceptCount++;
      if (expReqQ.size() == 0) begin
        failNow("unexpected_mem_request");
      end else begin
        e = expReqQ.pop_front();
        checkOutput("mem_we", 32'(mem_we), 32'(e.we));
        checkOutput("mem_addr", mem_addr, e.addr);
        if (e.we) begin
          checkOutput("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (mem_we) begin
        physMem[mem_addr] = mem_wdata;
      end else begin
        rdPending = 1'b1;
        rdCount   = $urandom_range(rdDelayMin, rdDelayMax);
        rdData    = physRead(mem_addr);
      end
    end
  end

  // Completion monitor: each done pulse must match the oldest expected pair
  // result; a pulse with nothing outstanding is itself a failure.
  always @(negedge clk) begin
    result_t r;
    if (rst && done) begin
      doneCount++;
      if (expResQ.size() == 0) begin
        failNow("unexpected_done");
      end else begin
        r = expResQ.pop_front();
        checkOutput("rdataA", rdataA, r.a);
        checkOutput("rdataB", rdataB, r.b);
      end
    end
  end

  // Presents one instruction pair, records what the memory and the pipeline
  // should see (sequential program-order semantics), then follows stall until
  // done. expLat is the done cycle counted from the presentation cycle, or -1
  // when memory timing is random. With hold set the requests stay up through
  // the whole done cycle.
  task automatic applyStimulus(input logic ra, input logic wa, input logic [DW-1:0] aa, input logic [DW-1:0] da,
                               input logic rb, input logic wb, input logic [DW-1:0] ab, input logic [DW-1:0] db,
                               input bit hold, input int expLat);
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    memreq_t       m;
    bit            seen;
    @(negedge clk);
    #1;
    reqA = ra; weA = wa; addrA = aa; wdataA = da;
    reqB = rb; weB = wb; addrB = ab; wdataB = db;
    ea = lastA;
    eb = lastB;
    if (ra) begin
      m = '{we: wa, addr: aa, wdata: da};
      expReqQ.push_back(m);
      if (wa) refMem[aa] = da;
      else ea = refRead(aa);
    end
    if (rb) begin
      m = '{we: wb, addr: ab, wdata: db};
      expReqQ.push_back(m);
      if (wb) refMem[ab] = db;
      else eb = refRead(ab);
    end
    #1;
    checkOutput("stall_on_present", 32'(stall), 32'(ra || rb));
    if (!(ra || rb)) begin
      @(negedge clk);
      #1;
      checkOutput("idle_no_done", 32'(done), 32'd0);
      return;
    end
    expResQ.push_back('{a: ea, b: eb});
    lastA = ea;
    lastB = eb;
    seen = 1'b0;
    for (int c = 1; c <= 300 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        checkOutput("stall_at_done", 32'(stall), 32'd0);
        if (expLat >= 0) checkOutput("done_latency", 32'(c), 32'(expLat));
      end else begin
        checkOutput("stall_while_busy", 32'(stall), 32'd1);
      end
    end
    if (!seen) failNow("done_timeout");
    if (hold) begin
      @(posedge clk);
      #1;
    end
    reqA = 1'b0;
    reqB = 1'b0;
  endtask

  // Hard watchdog in case something blocks outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog_expired");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset checks, the directed scenarios, then randomized
  // pairs against the reference model with random memory timing.
  initial begin
    int base;
    bit got;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_rdataA", rdataA, 32'd0);
    checkOutput("reset_rdataB", rdataB, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("post_reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("post_reset_stall", 32'(stall), 32'd0);

    $display("[TB] single load");
    preload(32'h100, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3);

    $display("[TB] store A then aliasing load B");
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h11, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 4);

    $display("[TB] lane B only");
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 3);

    $display("[TB] pair of loads, zero wait");
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 5);

    $display("[TB] store with mem_ready low for 3 cycles");
    readyHold = 3;
    applyStimulus(1'b1, 1'b1, 32'h20, 32'hCAFE_0020, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5);
    readyHold = 0;

    $display("[TB] reset during WAIT_B");
    rdDelayMin = 4;
    rdDelayMax = 4;
    base = acceptCount;
    @(negedge clk);
    #1;
    reqA = 1'b1; weA = 1'b0; addrA = 32'h100;
    reqB = 1'b1; weB = 1'b0; addrB = 32'h8;
    expReqQ.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    expReqQ.push_back('{we: 1'b0, addr: 32'h8, wdata: 32'h0});
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      #1;
      if (acceptCount == base + 2) got = 1'b1;
    end
    if (!got) failNow("reset_test_accept_timeout");
    base = doneCount;
    @(negedge clk);
    rst = 1'b0;
    reqA = 1'b0;
    reqB = 1'b0;
    #1;
    checkOutput("async_reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("async_reset_stall", 32'(stall), 32'd0);
    checkOutput("async_reset_done", 32'(done), 32'd0);
    checkOutput("async_reset_rdataA", rdataA, 32'd0);
    checkOutput("async_reset_rdataB", rdataB, 32'd0);
    lastA = '0;
    lastB = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("late_rvalid_no_done", 32'(doneCount), 32'(base));
    checkOutput("late_rvalid_rdataA", rdataA, 32'd0);
    checkOutput("late_rvalid_rdataB", rdataB, 32'd0);
    checkOutput("late_rvalid_mem_req", 32'(mem_req), 32'd0);
    rdDelayMin = 1;
    rdDelayMax = 1;

    $display("[TB] stray rvalid and request held through done");
    spuriousEn = 1'b1;
    base = doneCount;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 3);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("single_done_pulse", 32'(doneCount), 32'(base + 1));
    checkOutput("back_to_idle_stall", 32'(stall), 32'd0);
    checkOutput("back_to_idle_mem_req", 32'(mem_req), 32'd0);

    $display("[TB] randomized pairs");
    readyPct = 60;
    rdDelayMin = 1;
    rdDelayMax = 3;
    for (int i = 0; i < 150; i++) begin
      ra = 32'h200 + 32'($urandom_range(0, 7)) * 4;
      rb = 32'h200 + 32'($urandom_range(0, 7)) * 4;
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra, $urandom,
                    ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rb, $urandom,
                    1'($urandom_range(0, 1)), -1);
    end

    repeat (8) @(negedge clk);
    #1;
    checkOutput("result_queue_drained", 32'(expResQ.size()), 32'd0);
    checkOutput("request_queue_drained", 32'(expReqQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
